// File: rtl/ex_issue_stage.sv
// ex_issue_stage
//   ID/EX pipeline register plus operand-issue logic feeding the ALU.
//   Captures decoded operands, resolves data hazards against EX/MEM and
//   MEM/WB by forwarding or stalling, and presents the ALU operands/opcode.
//
// Build option:
//   EX_FORWARDING_EN  defined   -> EX/MEM and MEM/WB forwarding, stall only on load-use.
//                     undefined -> no forwarding; stall whenever a used source register
//                                  matches a pending write in EX/MEM or MEM/WB.
//
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   id_*                           decoded instruction from the decode stage
//   stall, flush                   downstream hold / branch-redirect kill
//   exmem_*, memwb_*               destination info and results of later stages
//   alu_in1, alu_in2, alu_ctl      ALU operands and opcode
//   ex_issue                       stage holds a valid instruction that advances this cycle
//   ex_rd, ex_reg_write            destination info for EX/MEM (bubble while stalled)
//   ex_store_data                  forwarded rs2 value for stores
//   hazard_stall                   hold request to fetch and decode
module ex_issue_stage #(
    parameter int WORDSIZE = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                id_valid,
    input  logic [WORDSIZE-1:0] id_pc,
    input  logic [WORDSIZE-1:0] id_rs1_data,
    input  logic [WORDSIZE-1:0] id_rs2_data,
    input  logic [4:0]          id_rs1,
    input  logic [4:0]          id_rs2,
    input  logic [4:0]          id_rd,
    input  logic [WORDSIZE-1:0] id_imm,
    input  logic [3:0]          id_alu_ctl,
    input  logic                id_src1_pc,
    input  logic                id_src2_imm,
    input  logic                id_reg_write,
    input  logic                stall,
    input  logic                flush,
    input  logic [4:0]          exmem_rd,
    input  logic                exmem_reg_write,
    input  logic                exmem_mem_read,
    input  logic [WORDSIZE-1:0] exmem_result,
    input  logic [4:0]          memwb_rd,
    input  logic                memwb_reg_write,
    input  logic [WORDSIZE-1:0] memwb_result,
    output logic [WORDSIZE-1:0] alu_in1,
    output logic [WORDSIZE-1:0] alu_in2,
    output logic [3:0]          alu_ctl,
    output logic                ex_issue,
    output logic [4:0]          ex_rd,
    output logic                ex_reg_write,
    output logic [WORDSIZE-1:0] ex_store_data,
    output logic                hazard_stall
);

    // ADD encoding from the shared ALU opcode table; a bubble carries ADD.
    localparam logic [3:0] ALU_ADD = 4'b0000;

    logic                valid_p0;
    logic [WORDSIZE-1:0] pc_p0;
    logic [WORDSIZE-1:0] rs1_data_p0;
    logic [WORDSIZE-1:0] rs2_data_p0;
    logic [4:0]          rs1_p0;
    logic [4:0]          rs2_p0;
    logic [4:0]          rd_p0;
    logic [WORDSIZE-1:0] imm_p0;
    logic [3:0]          ctl_p0;
    logic                src1_pc_p0;
    logic                src2_imm_p0;
    logic                reg_write_p0;

    logic                hold;
    logic                exmem_hit1, exmem_hit2;
    logic                memwb_hit1, memwb_hit2;
    logic                rs1_used;
    logic [WORDSIZE-1:0] fwd_rs1, fwd_rs2;

    // A pending write to x0 never produces a match.
    function automatic logic stage_hit(input logic we, input logic [4:0] wrd, input logic [4:0] rs);
        return we && (wrd != 5'd0) && (wrd == rs);
    endfunction

    assign hold = stall | hazard_stall;

    // ---- ID -> EX register (p0) ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_p0     <= 1'b0;
            pc_p0        <= '0;
            rs1_data_p0  <= '0;
            rs2_data_p0  <= '0;
            rs1_p0       <= '0;
            rs2_p0       <= '0;
            rd_p0        <= '0;
            imm_p0       <= '0;
            ctl_p0       <= ALU_ADD;
            src1_pc_p0   <= 1'b0;
            src2_imm_p0  <= 1'b0;
            reg_write_p0 <= 1'b0;
        end else if (flush) begin
            // Kill wins over any hold; operand fields are left as they were.
            valid_p0     <= 1'b0;
            reg_write_p0 <= 1'b0;
            ctl_p0       <= ALU_ADD;
            rd_p0        <= '0;
        end else if (!hold) begin
            valid_p0     <= id_valid;
            pc_p0        <= id_pc;
            rs1_data_p0  <= id_rs1_data;
            rs2_data_p0  <= id_rs2_data;
            rs1_p0       <= id_rs1;
            rs2_p0       <= id_rs2;
            rd_p0        <= id_rd;
            imm_p0       <= id_imm;
            ctl_p0       <= id_alu_ctl;
            src1_pc_p0   <= id_src1_pc;
            src2_imm_p0  <= id_src2_imm;
            reg_write_p0 <= id_reg_write;
        end
    end

    // ---- EX issue: hazard resolution and operand select ----
    assign exmem_hit1 = stage_hit(exmem_reg_write, exmem_rd, rs1_p0);
    assign exmem_hit2 = stage_hit(exmem_reg_write, exmem_rd, rs2_p0);
    assign memwb_hit1 = stage_hit(memwb_reg_write, memwb_rd, rs1_p0);
    assign memwb_hit2 = stage_hit(memwb_reg_write, memwb_rd, rs2_p0);

    // rs2 always counts as used: store data is taken from it even when imm feeds the ALU.
    assign rs1_used = !src1_pc_p0;

`ifdef EX_FORWARDING_EN
    assign fwd_rs1 = exmem_hit1 ? exmem_result : (memwb_hit1 ? memwb_result : rs1_data_p0);
    assign fwd_rs2 = exmem_hit2 ? exmem_result : (memwb_hit2 ? memwb_result : rs2_data_p0);

    // Only a load in EX/MEM cannot be forwarded yet; everything else is bypassed.
    assign hazard_stall = valid_p0 & exmem_mem_read & ((exmem_hit1 & rs1_used) | exmem_hit2);
`else
    assign fwd_rs1 = rs1_data_p0;
    assign fwd_rs2 = rs2_data_p0;

    // Without bypass paths, wait until neither later stage still owes a used register.
    assign hazard_stall = valid_p0 &
                          (((exmem_hit1 | memwb_hit1) & rs1_used) | exmem_hit2 | memwb_hit2);

    // Result and load-flag ports have no consumer in this build.
    logic unused_nofwd;
    assign unused_nofwd = ^{exmem_mem_read, exmem_result, memwb_result};
`endif

    assign alu_in1       = src1_pc_p0 ? pc_p0 : fwd_rs1;
    assign alu_in2       = src2_imm_p0 ? imm_p0 : fwd_rs2;
    assign alu_ctl       = ctl_p0;
    assign ex_store_data = fwd_rs2;
    assign ex_rd         = rd_p0;
    assign ex_issue      = valid_p0 & ~hazard_stall & ~stall;
    assign ex_reg_write  = reg_write_p0 & ex_issue;

endmodule

// File: tb/tb_ex_issue_stage.sv
module tb_ex_issue_stage;

    logic        clk;
    logic        rst;
    logic        id_valid;
    logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [3:0]  id_alu_ctl;
    logic        id_src1_pc, id_src2_imm, id_reg_write;
    logic        stall, flush;
    logic [4:0]  exmem_rd;
    logic        exmem_reg_write, exmem_mem_read;
    logic [31:0] exmem_result;
    logic [4:0]  memwb_rd;
    logic        memwb_reg_write;
    logic [31:0] memwb_result;
    logic [31:0] alu_in1, alu_in2, ex_store_data;
    logic [3:0]  alu_ctl;
    logic        ex_issue, ex_reg_write, hazard_stall;
    logic [4:0]  ex_rd;

    int checks = 0;
    int failures = 0;

    ex_issue_stage #(.WORDSIZE(32)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_pc(id_pc),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_imm(id_imm), .id_alu_ctl(id_alu_ctl),
        .id_src1_pc(id_src1_pc), .id_src2_imm(id_src2_imm), .id_reg_write(id_reg_write),
        .stall(stall), .flush(flush),
        .exmem_rd(exmem_rd), .exmem_reg_write(exmem_reg_write),
        .exmem_mem_read(exmem_mem_read), .exmem_result(exmem_result),
        .memwb_rd(memwb_rd), .memwb_reg_write(memwb_reg_write), .memwb_result(memwb_result),
        .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_ctl(alu_ctl),
        .ex_issue(ex_issue), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
        .ex_store_data(ex_store_data), .hazard_stall(hazard_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle away from the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_instr(input logic [31:0] pc, input logic [4:0] rs1, input logic [31:0] d1,
                              input logic [4:0] rs2, input logic [31:0] d2, input logic [4:0] rd,
                              input logic [31:0] imm, input logic [3:0] ctl,
                              input logic s1pc, input logic s2imm, input logic rw);
        id_valid     = 1'b1;
        id_pc        = pc;
        id_rs1       = rs1;
        id_rs1_data  = d1;
        id_rs2       = rs2;
        id_rs2_data  = d2;
        id_rd        = rd;
        id_imm       = imm;
        id_alu_ctl   = ctl;
        id_src1_pc   = s1pc;
        id_src2_imm  = s2imm;
        id_reg_write = rw;
    endtask

    task automatic clear_fwd();
        exmem_rd = 5'd0; exmem_reg_write = 1'b0; exmem_mem_read = 1'b0; exmem_result = 32'h0;
        memwb_rd = 5'd0; memwb_reg_write = 1'b0; memwb_result = 32'h0;
    endtask

    initial begin
        rst = 1'b1;
        stall = 1'b0;
        flush = 1'b0;
        // Random traffic on every input while reset is held.
        load_instr($urandom, 5'($urandom), $urandom, 5'($urandom), $urandom, 5'($urandom),
                   $urandom, 4'hF, 1'($urandom), 1'($urandom), 1'b1);
        exmem_rd = 5'($urandom); exmem_reg_write = 1'b1; exmem_mem_read = 1'b1;
        exmem_result = $urandom;
        memwb_rd = 5'($urandom); memwb_reg_write = 1'b1; memwb_result = $urandom;
        step();
        step();
        chk("rst_ex_issue",     32'(ex_issue), 32'd0);
        chk("rst_hazard",       32'(hazard_stall), 32'd0);
        chk("rst_ex_reg_write", 32'(ex_reg_write), 32'd0);
        chk("rst_ex_rd",        32'(ex_rd), 32'd0);
        chk("rst_alu_ctl",      32'(alu_ctl), 32'd0);
        chk("rst_alu_in1",      alu_in1, 32'd0);
        chk("rst_alu_in2",      alu_in2, 32'd0);
        chk("rst_store",        ex_store_data, 32'd0);

        // Release reset and present instruction A.
        clear_fwd();
        rst = 1'b0;
        load_instr(32'h100, 5'd5, 32'h11, 5'd6, 32'h22, 5'd7, 32'h40, 4'h3, 1'b0, 1'b0, 1'b1);
        #1;
        chk("pre_capture_issue", 32'(ex_issue), 32'd0);
        step();
        chk("A_alu_in1",  alu_in1, 32'h11);
        chk("A_alu_in2",  alu_in2, 32'h22);
        chk("A_alu_ctl",  32'(alu_ctl), 32'h3);
        chk("A_issue",    32'(ex_issue), 32'd1);
        chk("A_rd",       32'(ex_rd), 32'd7);
        chk("A_reg_write",32'(ex_reg_write), 32'd1);
        chk("A_store",    ex_store_data, 32'h22);

        // EX/MEM and MEM/WB both target rs1 = 5.
        exmem_rd = 5'd5; exmem_reg_write = 1'b1; exmem_result = 32'h1234;
        memwb_rd = 5'd5; memwb_reg_write = 1'b1; memwb_result = 32'h9999;
        #1;
`ifdef EX_FORWARDING_EN
        chk("fwd_exmem_in1",    alu_in1, 32'h1234);
        chk("fwd_exmem_hazard", 32'(hazard_stall), 32'd0);
        chk("fwd_exmem_issue",  32'(ex_issue), 32'd1);
`else
        chk("nofwd_in1",        alu_in1, 32'h11);
        chk("nofwd_hazard",     32'(hazard_stall), 32'd1);
        chk("nofwd_issue",      32'(ex_issue), 32'd0);
        chk("nofwd_reg_write",  32'(ex_reg_write), 32'd0);
`endif
        exmem_reg_write = 1'b0;
        #1;
`ifdef EX_FORWARDING_EN
        chk("fwd_memwb_in1", alu_in1, 32'h9999);
`else
        chk("nofwd_memwb_in1",    alu_in1, 32'h11);
        chk("nofwd_memwb_hazard", 32'(hazard_stall), 32'd1);
`endif
        clear_fwd();

        // Instruction B: rs2 = x0, later stages write x0.
        load_instr(32'h104, 5'd3, 32'h33, 5'd0, 32'h55, 5'd8, 32'h0, 4'h2, 1'b0, 1'b0, 1'b1);
        step();
        exmem_rd = 5'd0; exmem_reg_write = 1'b1; exmem_result = 32'hDEAD;
        memwb_rd = 5'd0; memwb_reg_write = 1'b1; memwb_result = 32'hBEEF;
        #1;
        chk("x0_alu_in2", alu_in2, 32'h55);
        chk("x0_store",   ex_store_data, 32'h55);
        chk("x0_hazard",  32'(hazard_stall), 32'd0);
        clear_fwd();

        // Instruction C, then a load in EX/MEM writing its rs1.
        load_instr(32'h108, 5'd9, 32'h90, 5'd10, 32'hA0, 5'd11, 32'h0, 4'h1, 1'b0, 1'b0, 1'b1);
        step();
        load_instr(32'h200, 5'd12, 32'hC0, 5'd13, 32'hD0, 5'd14, 32'h8, 4'h5, 1'b1, 1'b1, 1'b1);
        exmem_rd = 5'd9; exmem_reg_write = 1'b1; exmem_mem_read = 1'b1; exmem_result = 32'hBAD;
        #1;
        chk("lu_hazard",    32'(hazard_stall), 32'd1);
        chk("lu_issue",     32'(ex_issue), 32'd0);
        chk("lu_reg_write", 32'(ex_reg_write), 32'd0);
        step();
        // Load has moved to MEM/WB; EX/MEM now holds a bubble.
        clear_fwd();
        memwb_rd = 5'd9; memwb_reg_write = 1'b1; memwb_result = 32'h4444;
        #1;
        chk("lu_held_rd", 32'(ex_rd), 32'd11);
`ifdef EX_FORWARDING_EN
        chk("lu_next_hazard", 32'(hazard_stall), 32'd0);
        chk("lu_next_issue",  32'(ex_issue), 32'd1);
        chk("lu_next_in1",    alu_in1, 32'h4444);
`else
        chk("lu_next_hazard", 32'(hazard_stall), 32'd1);
        chk("lu_next_issue",  32'(ex_issue), 32'd0);
        chk("lu_next_in1",    alu_in1, 32'h90);
`endif
        clear_fwd();
        #1;
        chk("lu_clear_issue", 32'(ex_issue), 32'd1);
        chk("lu_clear_in1",   alu_in1, 32'h90);
        step();

        // Instruction D: PC and immediate operands.
        chk("D_alu_in1", alu_in1, 32'h200);
        chk("D_alu_in2", alu_in2, 32'h8);
        chk("D_store",   ex_store_data, 32'hD0);
        chk("D_alu_ctl", 32'(alu_ctl), 32'h5);
        exmem_rd = 5'd12; exmem_reg_write = 1'b1; exmem_mem_read = 1'b1;
        #1;
        chk("D_rs1_unused_hazard", 32'(hazard_stall), 32'd0);
        exmem_rd = 5'd13;
        #1;
        chk("D_rs2_store_hazard", 32'(hazard_stall), 32'd1);
        clear_fwd();

        // External stall holds D; next ID instruction E waits.
        load_instr(32'h300, 5'd1, 32'h1, 5'd2, 32'h2, 5'd15, 32'h0, 4'h7, 1'b0, 1'b0, 1'b1);
        stall = 1'b1;
        #1;
        chk("stall_issue",     32'(ex_issue), 32'd0);
        chk("stall_reg_write", 32'(ex_reg_write), 32'd0);
        step();
        chk("stall_held_rd",  32'(ex_rd), 32'd14);
        chk("stall_held_ctl", 32'(alu_ctl), 32'h5);

        // Flush together with stall leaves a bubble.
        flush = 1'b1;
        step();
        flush = 1'b0;
        stall = 1'b0;
        #1;
        chk("flush_issue",     32'(ex_issue), 32'd0);
        chk("flush_reg_write", 32'(ex_reg_write), 32'd0);
        chk("flush_alu_ctl",   32'(alu_ctl), 32'd0);
        chk("flush_rd",        32'(ex_rd), 32'd0);

        // Instruction F: imm on operand 2, MEM/WB writes rs2.
        load_instr(32'h400, 5'd1, 32'h11, 5'd2, 32'h22, 5'd3, 32'h77, 4'h4, 1'b0, 1'b1, 1'b1);
        step();
        memwb_rd = 5'd2; memwb_reg_write = 1'b1; memwb_result = 32'h5555;
        #1;
        chk("F_alu_in2", alu_in2, 32'h77);
`ifdef EX_FORWARDING_EN
        chk("F_hazard", 32'(hazard_stall), 32'd0);
        chk("F_store",  ex_store_data, 32'h5555);
`else
        chk("F_hazard", 32'(hazard_stall), 32'd1);
        chk("F_store",  ex_store_data, 32'h22);
`endif
        clear_fwd();
        #1;
        chk("F_issue", 32'(ex_issue), 32'd1);

        // Asynchronous reset between clock edges.
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_issue",   32'(ex_issue), 32'd0);
        chk("async_rst_ctl",     32'(alu_ctl), 32'd0);
        chk("async_rst_alu_in2", alu_in2, 32'd0);
        chk("async_rst_rd",      32'(ex_rd), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ex_issue_stage.md
# ex_issue_stage

ID/EX pipeline register and operand-issue logic that feeds the ALU. It captures decoded operands from the decode stage, resolves data hazards against the EX/MEM and MEM/WB stages by forwarding or stalling, and presents `alu_in1`, `alu_in2` and `alu_ctl` to the ALU. It also passes destination and store-data information to the EX/MEM register.

## Interface
- `WORDSIZE`, 32, datapath width
- `clk` input 1, rising-edge clock
- `rst` input 1, asynchronous active-high reset
- `id_valid` input 1, decode slot holds a real instruction
- `id_pc` input WORDSIZE, instruction PC
- `id_rs1_data`, `id_rs2_data` input WORDSIZE, register-file read data
- `id_rs1`, `id_rs2`, `id_rd` input 5, register indices
- `id_imm` input WORDSIZE, sign-extended immediate
- `id_alu_ctl` input 4, ALU opcode (`defines.vh` encodings)
- `id_src1_pc` input 1, 1 selects PC as operand 1, 0 selects rs1
- `id_src2_imm` input 1, 1 selects immediate as operand 2, 0 selects rs2
- `id_reg_write` input 1, instruction writes rd
- `stall` input 1, external hold from downstream
- `flush` input 1, kill the instruction in this stage (branch redirect)
- `exmem_rd` input 5, `exmem_reg_write` input 1, `exmem_mem_read` input 1, `exmem_result` input WORDSIZE
- `memwb_rd` input 5, `memwb_reg_write` input 1, `memwb_result` input WORDSIZE
- `alu_in1`, `alu_in2` output WORDSIZE, ALU operands
- `alu_ctl` output 4, ALU opcode
- `ex_issue` output 1, stage content is valid and advances this cycle
- `ex_rd` output 5, `ex_reg_write` output 1, passed through to EX/MEM
- `ex_store_data` output WORDSIZE, forwarded rs2 value, always rs2 even when the immediate is selected
- `hazard_stall` output 1, hold request to fetch and decode

## Operation
- The register holds these fields: valid, pc, rs1/rs2 data, rs1/rs2/rd, imm, ctl, src selects, reg_write.
- Internal hold is `stall | hazard_stall`.
- Update priority at each clock edge:
  - `flush` loads a bubble: valid=0, reg_write=0, ctl=`ADD`, rd=0. Flush wins over hold.
  - Otherwise, while hold is asserted, all fields keep their value.
  - Otherwise, all fields load from the `id_*` inputs.
- Forwarding is combinational on the registered rs1 and rs2, each resolved independently:
  - EX/MEM match: `exmem_reg_write & exmem_rd!=0 & exmem_rd==rs`. Highest priority.
  - MEM/WB match: `memwb_reg_write & memwb_rd!=0 & memwb_rd==rs`. Next priority.
  - Else the registered data is used.
  - x0 is never forwarded.
- Operand select: `alu_in1` = src1_pc ? pc : fwd_rs1. `alu_in2` = src2_imm ? imm : fwd_rs2.
- Load-use hazard: `hazard_stall` = valid & exmem_mem_read & EX/MEM match on an rs the instruction uses.
  - rs1 counts as used when !src1_pc. rs2 always counts, because store data needs it.
- `ex_issue` = valid & ~hazard_stall & ~stall.
- `ex_reg_write` = reg_write & ex_issue. Downstream sees a bubble while stalled.

## Timing
- Reset values: register fields 0, ctl=`ADD`. Outputs: `ex_issue`=0, `hazard_stall`=0, `ex_reg_write`=0, `ex_rd`=0, `alu_ctl`=`ADD`, `alu_in1`/`alu_in2`/`ex_store_data` = 0 (pc=0, data=0, imm=0).
- Latency: one cycle from `id_*` to `alu_*`. Forwarding and `hazard_stall` are same-cycle combinational with no added latency.
- A load-use hazard costs exactly one stall cycle; on the next cycle the value arrives from MEM/WB.
- `rst` asserted mid-operation clears the stage immediately, asynchronously.
- When `stall` and `flush` are asserted together, the stage becomes a bubble.
- While `hazard_stall` is asserted and the ID stage also holds, the instruction re-evaluates each cycle until the hazard clears.

## Configuration
- `EX_FORWARDING_EN` defined: forwarding and load-use detection behave as described above.
- `EX_FORWARDING_EN` undefined: no forwarding paths; the registered data is always used.
  - `hazard_stall` asserts whenever valid and either stage's match condition (EX/MEM or MEM/WB) is true for a used rs, regardless of mem_read.

## Test plan
- Reset: hold rst=1, apply random inputs -> all outputs 0, `alu_ctl`=`ADD`. Release -> first captured instruction appears 1 cycle later.
- EX/MEM forwarding: rs1=5, exmem_rd=5, exmem_reg_write=1, exmem_result=0x1234, memwb_rd=5, memwb_result=0x9999 -> `alu_in1`=0x1234.
- x0 guard: rs2=0, exmem_rd=0, exmem_reg_write=1, exmem_result=0xDEAD -> `alu_in2`=registered rs2 data.
- Load-use: exmem_mem_read=1 with exmem_rd==rs1 -> `hazard_stall`=1 and `ex_issue`=0 for one cycle. Next cycle memwb forwards -> `ex_issue`=1.
- Flush over stall: stall=1 and flush=1 on the same edge -> next cycle valid=0, `ex_reg_write`=0, `alu_ctl`=`ADD`.
- `EX_FORWARDING_EN` undefined: memwb_rd==rs2 with src2_imm=1 -> `hazard_stall`=1 and `alu_in2`=imm. The hazard is still raised because store data needs rs2.
